lpif_txrx_asym_gearbox: RTL and testbench
=========================================

Name: lpif_txrx_asym_gearbox

Overview:
- Parametrised, sequential successor to the fixed two-lane LPIF-to-logic-link packing.
- TX path: accepts one LPIF lane-beat per cycle on a valid/ready handshake, accumulates RATIO beats (gen2) or one beat (gen1) into one logic-link word, and presents the word to the TX FIFO with valid/ready.
- RX path: takes words from the RX FIFO and replays them as consecutive LPIF lane-beats.
- Sits between the LPIF adapter and the logic-link FIFOs.

Parameters:
- DATA_W, 64, LPIF data bits per lane-beat.
- RATIO, 2, lanes per link word in gen2 mode; legal values 1, 2, 4.
- LANE_W, DATA_W+11, derived: state 4 + protid 2 + data + dvalid 1 + crc 2 + crc_valid 1 + valid 1.
- WORD_W, RATIO*LANE_W, derived link word width (150 at defaults).

Ports:
- clk_wr  in  1  single block clock.
- rst_wr_n  in  1  reset, asynchronous assert, active-low.
- m_gen2_mode  in  1  1: RATIO lanes per word; 0: 1 lane per word.
- dstrm_state/protid/data/dvalid/crc/crc_valid/valid  in  4/2/DATA_W/1/2/1/1  one TX lane-beat.
- dstrm_beat_vld  in  1  TX lane-beat present.
- dstrm_beat_rdy  out  1  TX lane-beat accepted when vld&&rdy.
- txfifo_downstream_data  out  WORD_W  packed link word.
- txfifo_downstream_vld  out  1  word valid.
- txfifo_downstream_rdy  in  1  FIFO accepts word.
- rxfifo_upstream_data  in  WORD_W  received link word.
- rxfifo_upstream_vld  in  1  word valid.
- rxfifo_upstream_rdy  out  1  block accepts word.
- ustrm_state/protid/data/dvalid/crc/crc_valid/valid  out  4/2/DATA_W/1/2/1/1  one RX lane-beat.
- ustrm_beat_vld  out  1  RX lane-beat valid.
- ustrm_beat_rdy  in  1  consumer takes beat.

Behaviour:
- Lane layout, lane k at bit k*LANE_W, LSB first within the lane: state, protid, data, dvalid, crc, crc_valid, valid.
- Lane 0 is the first beat in time.
- Effective ratio R = m_gen2_mode ? RATIO : 1.
- Mode is latched into mode_q only when tx_cnt==0 and rx_cnt==0. A mode change while mid-word is ignored until both counters are idle.
- In gen1, lanes 1..RATIO-1 of TX words are driven zero, and the same lanes of RX words are ignored.

Reset (rst_wr_n low, asynchronous):
- tx_cnt, rx_cnt and mode_q go to 0; mode_q re-latches on the first idle cycle after reset.
- Accumulator, output word register and RX word register are cleared.
- txfifo_downstream_vld=0, txfifo_downstream_data=0, ustrm_beat_vld=0, all ustrm_* fields=0.
- dstrm_beat_rdy=1, rxfifo_upstream_rdy=1.
- A reset mid-word discards the partial word; nothing is emitted.

TX path:
- Beats 0..R-2 are written into accumulator lane tx_cnt and tx_cnt increments.
- The last beat (tx_cnt==R-1) loads the output register with accumulator plus the incoming lane and sets tx_cnt=0. txfifo_downstream_vld=1 from the next cycle (latency 1 after the last beat).
- dstrm_beat_rdy = !(tx_cnt==R-1 && out_vld && !txfifo_downstream_rdy). Non-last beats are always accepted.
- If out_vld, txfifo_downstream_rdy=1 and a last beat is accepted in the same cycle, the new word replaces the old one and out_vld stays 1. Sustained throughput is one word per R cycles.
- If out_vld and txfifo_downstream_rdy with no load, out_vld clears.
- Data is held stable while vld && !rdy.

RX path:
- rxfifo_upstream_rdy = !rx_vld || (rx_cnt==R-1 && ustrm_beat_rdy).
- An accepted word goes to rx_word with rx_vld=1 and rx_cnt=0. Beat 0 appears on ustrm_* the next cycle.
- ustrm_* is driven combinationally from rx_word lane rx_cnt; ustrm_beat_vld=rx_vld.
- ustrm_* outputs are zero when !rx_vld.
- On ustrm_beat_rdy: rx_cnt increments. At R-1, rx_cnt=0 and rx_vld clears, unless a new word loads in the same cycle, in which case rx_vld stays 1 (back-to-back, no bubble).
- TX and RX paths are fully independent apart from the mode latch.

Test Plan:
- Gen2, RATIO=2, txfifo_rdy=1; beat A (state 4'h3, data 64'h1111_1111_1111_1111, valid 1), then beat B (data 64'h2222_2222_2222_2222) -> exactly one word, vld one cycle after B; [74:0] = A fields, [149:75] = B fields, with data at bits 6 and 81.
- Backpressure, txfifo_rdy=0, four consecutive beats offered -> beats 1–3 accepted, beat 4 sees dstrm_beat_rdy=0. Raising txfifo_rdy for one cycle pops word1 and accepts beat 4 -> word2 is valid next cycle.
- Gen1 mode, three beats -> three words, each with lane 1 bits [149:75] == 0 and lane 0 equal to its beat.
- RX: two back-to-back words {X0,X1},{Y0,Y1} with ustrm_beat_rdy=1 -> beats X0,X1,Y0,Y1 on four consecutive cycles, and rxfifo_upstream_rdy=1 on the X1 cycle.
- Reset mid-word: accept one beat, pulse rst_wr_n low -> all outputs at reset values immediately. The next two beats form a clean word with no trace of the discarded beat.
- RATIO=4, toggle m_gen2_mode mid-word -> current word still uses the old ratio; the change takes effect only once tx_cnt and rx_cnt are both 0.

Source files
------------

// File: rtl/lpif_txrx_asym_gearbox.sv
// LPIF lane-beat <-> logic-link word gearbox.
// TX packs R beats per word, RX replays words as R beats (R = gen2 ? RATIO : 1).
module lpif_txrx_asym_gearbox #(
    parameter  int DATA_W = 64,
    parameter  int RATIO  = 2,
    localparam int LANE_W = DATA_W + 11,
    localparam int WORD_W = RATIO * LANE_W
) (
    input  logic              clk_wr,
    input  logic              rst_wr_n,
    input  logic              m_gen2_mode,
    input  logic [3:0]        dstrm_state,
    input  logic [1:0]        dstrm_protid,
    input  logic [DATA_W-1:0] dstrm_data,
    input  logic              dstrm_dvalid,
    input  logic [1:0]        dstrm_crc,
    input  logic              dstrm_crc_valid,
    input  logic              dstrm_valid,
    input  logic              dstrm_beat_vld,
    output logic              dstrm_beat_rdy,
    output logic [WORD_W-1:0] txfifo_downstream_data,
    output logic              txfifo_downstream_vld,
    input  logic              txfifo_downstream_rdy,
    input  logic [WORD_W-1:0] rxfifo_upstream_data,
    input  logic              rxfifo_upstream_vld,
    output logic              rxfifo_upstream_rdy,
    output logic [3:0]        ustrm_state,
    output logic [1:0]        ustrm_protid,
    output logic [DATA_W-1:0] ustrm_data,
    output logic              ustrm_dvalid,
    output logic [1:0]        ustrm_crc,
    output logic              ustrm_crc_valid,
    output logic              ustrm_valid,
    output logic              ustrm_beat_vld,
    input  logic              ustrm_beat_rdy
);

    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CW-1:0] LAST_G2 = CW'(RATIO - 1);

    logic              mode_q;
    logic              idle, mode_eff;
    logic [CW-1:0]     r_last;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [CW-1:0]     rx_cnt_q, rx_cnt_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] out_q, out_d;
    logic [WORD_W-1:0] rx_word_q, rx_word_d;
    logic [WORD_W-1:0] tx_word;
    logic              out_vld_q, out_vld_d;
    logic              rx_vld_q, rx_vld_d;
    logic [LANE_W-1:0] tx_lane, rx_lane;
    logic              tx_last, rx_last, tx_fire, rx_load;

    // While idle the live mode applies, so the first word after a change already uses it.
    assign idle     = (tx_cnt_q == '0) && (rx_cnt_q == '0);
    assign mode_eff = idle ? m_gen2_mode : mode_q;
    assign r_last   = mode_eff ? LAST_G2 : '0;

    assign tx_lane = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                      dstrm_data, dstrm_protid, dstrm_state};
    assign tx_last = (tx_cnt_q == r_last);
    assign dstrm_beat_rdy = !(tx_last && out_vld_q && !txfifo_downstream_rdy);
    assign tx_fire = dstrm_beat_vld && dstrm_beat_rdy;

    assign txfifo_downstream_data = out_q;
    assign txfifo_downstream_vld  = out_vld_q;

    always_comb begin
        acc_d     = acc_q;
        out_d     = out_q;
        out_vld_d = out_vld_q;
        tx_cnt_d  = tx_cnt_q;
        tx_word   = mode_eff ? acc_q : '0;
        tx_word[int'(tx_cnt_q)*LANE_W +: LANE_W] = tx_lane;
        if (out_vld_q && txfifo_downstream_rdy) out_vld_d = 1'b0;
        if (tx_fire) begin
            if (tx_last) begin
                out_d     = tx_word;
                out_vld_d = 1'b1;
                tx_cnt_d  = '0;
                acc_d     = '0;
            end else begin
                acc_d[int'(tx_cnt_q)*LANE_W +: LANE_W] = tx_lane;
                tx_cnt_d = tx_cnt_q + 1'b1;
            end
        end
    end

    assign rx_last = (rx_cnt_q == r_last);
    assign rxfifo_upstream_rdy = !rx_vld_q || (rx_last && ustrm_beat_rdy);
    assign rx_load = rxfifo_upstream_vld && rxfifo_upstream_rdy;

    always_comb begin
        rx_word_d = rx_word_q;
        rx_vld_d  = rx_vld_q;
        rx_cnt_d  = rx_cnt_q;
        if (rx_vld_q && ustrm_beat_rdy) begin
            if (rx_last) begin
                rx_cnt_d = '0;
                rx_vld_d = 1'b0;
            end else begin
                rx_cnt_d = rx_cnt_q + 1'b1;
            end
        end
        if (rx_load) begin
            rx_word_d = rxfifo_upstream_data;
            rx_vld_d  = 1'b1;
            rx_cnt_d  = '0;
        end
    end

    assign rx_lane = rx_vld_q ? rx_word_q[int'(rx_cnt_q)*LANE_W +: LANE_W] : '0;
    assign {ustrm_valid, ustrm_crc_valid, ustrm_crc, ustrm_dvalid,
            ustrm_data, ustrm_protid, ustrm_state} = rx_lane;
    assign ustrm_beat_vld = rx_vld_q;

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            mode_q    <= 1'b0;
            tx_cnt_q  <= '0;
            rx_cnt_q  <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
            rx_word_q <= '0;
            rx_vld_q  <= 1'b0;
        end else begin
            if (idle) mode_q <= m_gen2_mode;
            tx_cnt_q  <= tx_cnt_d;
            rx_cnt_q  <= rx_cnt_d;
            acc_q     <= acc_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
            rx_word_q <= rx_word_d;
            rx_vld_q  <= rx_vld_d;
        end
    end

endmodule

// File: tb/tb_lpif_txrx_asym_gearbox.sv
// Directed bench for lpif_txrx_asym_gearbox with word/beat scoreboards.
// Instance a: RATIO=2; instance b: RATIO=4 (TX only).
module tb_lpif_txrx_asym_gearbox;

    localparam int LW = 75;
    localparam int WA = 150;
    localparam int WB = 300;

    logic clk = 1'b0;
    logic rst_n;

    logic          a_gen2, a_bvld, a_txrdy, a_rxvld, a_urdy;
    logic [LW-1:0] a_lane;
    logic [WA-1:0] a_rxdata;
    wire           a_brdy, a_txvld, a_rxrdy, a_uvld;
    wire  [WA-1:0] a_txdata;
    wire  [LW-1:0] a_ul;

    logic          b_gen2, b_bvld, b_txrdy, b_rxvld, b_urdy;
    logic [LW-1:0] b_lane;
    logic [WB-1:0] b_rxdata;
    wire           b_brdy, b_txvld, b_rxrdy, b_uvld;
    wire  [WB-1:0] b_txdata;
    wire  [LW-1:0] b_ul;

    int n_chk  = 0;
    int n_fail = 0;

    logic [WA-1:0] txq[$];
    logic [LW-1:0] rxq[$];
    logic [WB-1:0] tbq[$];
    logic [LW-1:0] ln[25];

    always #5 clk = ~clk;

    lpif_txrx_asym_gearbox #(.DATA_W(64), .RATIO(2)) dut_a (
        .clk_wr(clk), .rst_wr_n(rst_n), .m_gen2_mode(a_gen2),
        .dstrm_state(a_lane[3:0]), .dstrm_protid(a_lane[5:4]),
        .dstrm_data(a_lane[69:6]), .dstrm_dvalid(a_lane[70]),
        .dstrm_crc(a_lane[72:71]), .dstrm_crc_valid(a_lane[73]),
        .dstrm_valid(a_lane[74]),
        .dstrm_beat_vld(a_bvld), .dstrm_beat_rdy(a_brdy),
        .txfifo_downstream_data(a_txdata), .txfifo_downstream_vld(a_txvld),
        .txfifo_downstream_rdy(a_txrdy),
        .rxfifo_upstream_data(a_rxdata), .rxfifo_upstream_vld(a_rxvld),
        .rxfifo_upstream_rdy(a_rxrdy),
        .ustrm_state(a_ul[3:0]), .ustrm_protid(a_ul[5:4]),
        .ustrm_data(a_ul[69:6]), .ustrm_dvalid(a_ul[70]),
        .ustrm_crc(a_ul[72:71]), .ustrm_crc_valid(a_ul[73]),
        .ustrm_valid(a_ul[74]),
        .ustrm_beat_vld(a_uvld), .ustrm_beat_rdy(a_urdy)
    );

    lpif_txrx_asym_gearbox #(.DATA_W(64), .RATIO(4)) dut_b (
        .clk_wr(clk), .rst_wr_n(rst_n), .m_gen2_mode(b_gen2),
        .dstrm_state(b_lane[3:0]), .dstrm_protid(b_lane[5:4]),
        .dstrm_data(b_lane[69:6]), .dstrm_dvalid(b_lane[70]),
        .dstrm_crc(b_lane[72:71]), .dstrm_crc_valid(b_lane[73]),
        .dstrm_valid(b_lane[74]),
        .dstrm_beat_vld(b_bvld), .dstrm_beat_rdy(b_brdy),
        .txfifo_downstream_data(b_txdata), .txfifo_downstream_vld(b_txvld),
        .txfifo_downstream_rdy(b_txrdy),
        .rxfifo_upstream_data(b_rxdata), .rxfifo_upstream_vld(b_rxvld),
        .rxfifo_upstream_rdy(b_rxrdy),
        .ustrm_state(b_ul[3:0]), .ustrm_protid(b_ul[5:4]),
        .ustrm_data(b_ul[69:6]), .ustrm_dvalid(b_ul[70]),
        .ustrm_crc(b_ul[72:71]), .ustrm_crc_valid(b_ul[73]),
        .ustrm_valid(b_ul[74]),
        .ustrm_beat_vld(b_uvld), .ustrm_beat_rdy(b_urdy)
    );

    task automatic chk(input string tag, input logic [WB-1:0] obs,
                       input logic [WB-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] mk(input logic [3:0] st,
                                         input logic [1:0] pid,
                                         input logic [63:0] d,
                                         input logic [1:0] crc);
        return {1'b1, crc[0], crc, 1'b1, d, pid, st};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (a_txvld && a_txrdy) begin
                if (txq.size() == 0) begin
                    n_fail++;
                    $error("FAIL a_tx_extra: observed %0h expected none", a_txdata);
                end else chk("a_tx_word", WB'(a_txdata), WB'(txq.pop_front()));
            end
            if (a_uvld && a_urdy) begin
                if (rxq.size() == 0) begin
                    n_fail++;
                    $error("FAIL a_rx_extra: observed %0h expected none", a_ul);
                end else chk("a_rx_beat", WB'(a_ul), WB'(rxq.pop_front()));
            end
            if (b_txvld && b_txrdy) begin
                if (tbq.size() == 0) begin
                    n_fail++;
                    $error("FAIL b_tx_extra: observed %0h expected none", b_txdata);
                end else chk("b_tx_word", b_txdata, tbq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 25; i++)
            ln[i] = mk(4'(i + 3), 2'(i), {16{4'(i + 1)}}, 2'(i + 1));
        rst_n = 1'b0;
        a_gen2 = 1'b1; a_bvld = 1'b0; a_txrdy = 1'b1;
        a_rxvld = 1'b0; a_urdy = 1'b1; a_lane = '0; a_rxdata = '0;
        b_gen2 = 1'b1; b_bvld = 1'b0; b_txrdy = 1'b1;
        b_rxvld = 1'b0; b_urdy = 1'b1; b_lane = '0; b_rxdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txvld", a_txvld, 0);
        chk("rst_txdata", a_txdata, 0);
        chk("rst_brdy", a_brdy, 1);
        chk("rst_rxrdy", a_rxrdy, 1);
        chk("rst_uvld", a_uvld, 0);
        chk("rst_ustrm", a_ul, 0);
        rst_n = 1'b1;

        // gen2 pack of two beats
        txq.push_back({ln[1], ln[0]});
        a_lane = ln[0]; a_bvld = 1'b1;
        step();
        chk("t1_vld_after_a", a_txvld, 0);
        a_lane = ln[1];
        step();
        a_bvld = 1'b0;
        chk("t1_vld_after_b", a_txvld, 1);
        chk("t1_lane0_data", a_txdata[6 +: 64], 64'h1111_1111_1111_1111);
        chk("t1_lane1_data", a_txdata[81 +: 64], 64'h2222_2222_2222_2222);
        step(); step();
        chk("t1_single_word", a_txvld, 0);
        chk("t1_q_empty", txq.size(), 0);

        // backpressure
        txq.push_back({ln[3], ln[2]});
        txq.push_back({ln[5], ln[4]});
        a_txrdy = 1'b0;
        a_lane = ln[2]; a_bvld = 1'b1;
        chk("t2_rdy_b1", a_brdy, 1);
        step();
        a_lane = ln[3];
        chk("t2_rdy_b2", a_brdy, 1);
        step();
        a_lane = ln[4];
        chk("t2_rdy_b3", a_brdy, 1);
        step();
        a_lane = ln[5];
        chk("t2_rdy_b4", a_brdy, 0);
        step();
        chk("t2_hold_rdy", a_brdy, 0);
        chk("t2_hold_data", a_txdata, {ln[3], ln[2]});
        a_txrdy = 1'b1;
        #1;
        chk("t2_rdy_pop", a_brdy, 1);
        step();
        a_bvld = 1'b0; a_txrdy = 1'b0;
        chk("t2_w2_vld", a_txvld, 1);
        chk("t2_w2_data", a_txdata, {ln[5], ln[4]});
        a_txrdy = 1'b1;
        step();
        chk("t2_drained", a_txvld, 0);
        chk("t2_q_empty", txq.size(), 0);

        // gen1: one beat per word, upper lane zero
        a_gen2 = 1'b0;
        for (int i = 6; i < 9; i++) txq.push_back({{LW{1'b0}}, ln[i]});
        a_bvld = 1'b1;
        a_lane = ln[6];
        step();
        chk("t3_vld", a_txvld, 1);
        a_lane = ln[7];
        step();
        a_lane = ln[8];
        step();
        a_bvld = 1'b0;
        chk("t3_upper_zero", a_txdata[149:75], 0);
        step(); step();
        chk("t3_q_empty", txq.size(), 0);

        // RX back-to-back replay
        a_gen2 = 1'b1;
        for (int i = 9; i < 13; i++) rxq.push_back(ln[i]);
        a_rxdata = {ln[10], ln[9]}; a_rxvld = 1'b1;
        chk("t4_rdy_idle", a_rxrdy, 1);
        step();
        a_rxdata = {ln[12], ln[11]};
        chk("t4_x0", a_ul, ln[9]);
        chk("t4_rdy_x0", a_rxrdy, 0);
        step();
        chk("t4_x1", a_ul, ln[10]);
        chk("t4_rdy_x1", a_rxrdy, 1);
        step();
        a_rxvld = 1'b0;
        chk("t4_y0", a_ul, ln[11]);
        chk("t4_y0_vld", a_uvld, 1);
        step();
        chk("t4_y1", a_ul, ln[12]);
        step();
        chk("t4_idle_vld", a_uvld, 0);
        chk("t4_idle_zero", a_ul, 0);
        chk("t4_q_empty", rxq.size(), 0);

        // reset mid-word
        a_lane = ln[13]; a_bvld = 1'b1;
        step();
        a_bvld = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_txvld", a_txvld, 0);
        chk("t5_rst_txdata", a_txdata, 0);
        chk("t5_rst_brdy", a_brdy, 1);
        chk("t5_rst_rxrdy", a_rxrdy, 1);
        chk("t5_rst_uvld", a_uvld, 0);
        #2;
        rst_n = 1'b1;
        txq.push_back({ln[15], ln[14]});
        a_lane = ln[14]; a_bvld = 1'b1;
        step();
        chk("t5_no_early", a_txvld, 0);
        a_lane = ln[15];
        step();
        a_bvld = 1'b0;
        chk("t5_vld", a_txvld, 1);
        chk("t5_clean_word", a_txdata, {ln[15], ln[14]});
        step(); step();
        chk("t5_q_empty", txq.size(), 0);

        // RATIO=4 with mode toggled mid-word
        tbq.push_back({ln[19], ln[18], ln[17], ln[16]});
        b_lane = ln[16]; b_bvld = 1'b1;
        step();
        b_lane = ln[17];
        step();
        b_gen2 = 1'b0;
        b_lane = ln[18];
        step();
        chk("t6_vld_p2", b_txvld, 0);
        b_lane = ln[19];
        step();
        chk("t6_vld_p3", b_txvld, 1);
        chk("t6_word4", b_txdata, {ln[19], ln[18], ln[17], ln[16]});
        tbq.push_back({{(3*LW){1'b0}}, ln[20]});
        b_lane = ln[20];
        step();
        chk("t6_g1_vld", b_txvld, 1);
        chk("t6_g1_word", b_txdata, {{(3*LW){1'b0}}, ln[20]});
        b_gen2 = 1'b1;
        tbq.push_back({ln[24], ln[23], ln[22], ln[21]});
        for (int i = 21; i < 24; i++) begin
            b_lane = ln[i];
            step();
        end
        chk("t6_vld_r2", b_txvld, 0);
        b_lane = ln[24];
        step();
        b_bvld = 1'b0;
        chk("t6_vld_r3", b_txvld, 1);
        chk("t6_word_r", b_txdata, {ln[24], ln[23], ln[22], ln[21]});
        repeat (3) step();
        chk("t6_q_empty", tbq.size(), 0);
        chk("end_a_txq", txq.size(), 0);
        chk("end_a_rxq", rxq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
